// File: rtl/bst_pkg.sv
// bst_pkg: shared constants and enums for the binary search tree controller
package bst_pkg;
    localparam int NODES = 7;
    localparam int KEY_W = 4;
    localparam logic [2:0] NULL_IDX = 3'd7;
    typedef enum logic [1:0] {OP_FIND = 2'b00, OP_INSERT = 2'b01, OP_CLEAR = 2'b10} op_t;
    typedef enum logic [1:0] {S_IDLE, S_WALK, S_LINK, S_RESP} state_t;
endpackage

// File: rtl/bst_node_mem.sv
// bst_node_mem: unreset key/left/right arrays with one async read port, node write and pointer update
module bst_node_mem
    import bst_pkg::*;
(
    input  logic             clk,
    input  logic [2:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key,
    output logic [2:0]       rd_left,
    output logic [2:0]       rd_right,
    input  logic             wr_en,
    input  logic [2:0]       wr_idx,
    input  logic [KEY_W-1:0] wr_key,
    input  logic             ptr_en,
    input  logic [2:0]       ptr_idx,
    input  logic             ptr_side,
    input  logic [2:0]       ptr_val
);
    logic [KEY_W-1:0] key_mem [NODES];
    logic [2:0]       left_mem [NODES];
    logic [2:0]       right_mem [NODES];

    assign rd_key   = key_mem[rd_idx];
    assign rd_left  = left_mem[rd_idx];
    assign rd_right = right_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_mem[wr_idx]   <= wr_key;
            left_mem[wr_idx]  <= NULL_IDX;
            right_mem[wr_idx] <= NULL_IDX;
        end
        if (ptr_en && ptr_side) right_mem[ptr_idx] <= ptr_val;
        if (ptr_en && !ptr_side) left_mem[ptr_idx] <= ptr_val;
    end
endmodule

// File: rtl/bst_ctrl.sv
// bst_ctrl: FSM sequencing FIND/INSERT/CLEAR over the node memory, one node per clock
module bst_ctrl
    import bst_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_found,
    output logic [2:0]       rsp_idx,
    output logic             rsp_err,
    output logic [2:0]       tree_counter,
    output logic             buf_empty,
    output logic             buf_full
);
    state_t           state, state_n;
    logic [2:0]       count, count_n, cur, vcnt;
    logic [KEY_W-1:0] key_q, rd_key;
    logic             ins_q, side_q;
    logic [2:0]       rd_left, rd_right, nxt;
    logic             lt, eq, null_c, ld, found_n, err_n, wr_en, ptr_en;
    logic [2:0]       idx_n;

    assign lt     = key_q < rd_key;
    assign eq     = key_q == rd_key;
    assign nxt    = lt ? rd_left : rd_right;
    assign null_c = nxt == NULL_IDX;

    // writes are gated by rst so a LINK coinciding with reset leaves the tree untouched
    assign wr_en  = rst && ((state == S_IDLE && cmd_valid && cmd_op == OP_INSERT && count == 3'd0) || state == S_LINK);
    assign ptr_en = rst && state == S_LINK;

    bst_node_mem u_mem (
        .clk(clk), .rd_idx(cur), .rd_key(rd_key), .rd_left(rd_left), .rd_right(rd_right),
        .wr_en(wr_en), .wr_idx(count), .wr_key(state == S_LINK ? key_q : cmd_key),
        .ptr_en(ptr_en), .ptr_idx(cur), .ptr_side(side_q), .ptr_val(count)
    );

    always_comb begin
        state_n = state;
        count_n = count;
        ld      = 1'b0;
        found_n = 1'b0;
        idx_n   = NULL_IDX;
        err_n   = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) begin
                state_n = S_RESP;
                ld      = 1'b1;
                if (cmd_op == OP_CLEAR) count_n = 3'd0;
                else if (cmd_op == OP_INSERT && count == 3'(NODES)) err_n = 1'b1;
                else if (cmd_op == OP_INSERT && count == 3'd0) begin
                    count_n = 3'd1;
                    idx_n   = 3'd0;
                end else if (count != 3'd0) begin
                    state_n = S_WALK;
                    ld      = 1'b0;
                end
            end
            S_WALK: begin
                state_n = S_RESP;
                ld      = 1'b1;
                if (eq) begin
                    found_n = 1'b1;
                    idx_n   = cur;
                end else if (!null_c) begin
                    err_n   = vcnt == 3'(NODES - 1);
                    ld      = err_n;
                    state_n = err_n ? S_RESP : S_WALK;
                end else if (ins_q) begin
                    state_n = S_LINK;
                    ld      = 1'b0;
                end
            end
            S_LINK: begin
                count_n = count + 3'd1;
                ld      = 1'b1;
                idx_n   = count;
                state_n = S_RESP;
            end
            default: state_n = rsp_ready ? S_IDLE : S_RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            count     <= 3'd0;
            rsp_found <= 1'b0;
            rsp_idx   <= NULL_IDX;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (ld) begin
                rsp_found <= found_n;
                rsp_idx   <= idx_n;
                rsp_err   <= err_n;
            end
            if (state == S_IDLE && cmd_valid) begin
                key_q <= cmd_key;
                ins_q <= cmd_op == OP_INSERT;
                cur   <= 3'd0;
                vcnt  <= 3'd0;
            end
            // on a null child cur stays on the parent for the LINK pointer update
            if (state == S_WALK && !eq) begin
                if (!null_c) cur <= nxt;
                vcnt   <= vcnt + 3'd1;
                side_q <= !lt;
            end
        end
    end

    assign cmd_ready    = rst && state == S_IDLE;
    assign rsp_valid    = state == S_RESP;
    assign tree_counter = count;
    assign buf_empty    = count == 3'd0;
    assign buf_full     = count == 3'(NODES);
endmodule

// File: tb/tb_bst_ctrl.sv
// tb_bst_ctrl: directed-vector self-checking bench for bst_ctrl
module tb_bst_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_key = 4'd0;
    logic       cmd_ready, rsp_valid, rsp_found, rsp_err, buf_empty, buf_full;
    logic [2:0] rsp_idx, tree_counter;
    int         vectors = 0, miscompares = 0;
    bit         auto_ack = 1'b1;
    int         f, i, e, lat;

    localparam logic [1:0] FIND = 2'b00, INS = 2'b01, CLR = 2'b10;

    always #5 clk = ~clk;

    bst_ctrl u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_found(rsp_found),
        .rsp_idx(rsp_idx), .rsp_err(rsp_err), .tree_counter(tree_counter),
        .buf_empty(buf_empty), .buf_full(buf_full)
    );

    task automatic check(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] key);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic collect(output int fo, output int io, output int eo, output int lo);
        lo = 0;
        do begin
            @(negedge clk);
            lo++;
        end while (!rsp_valid && lo < 20);
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        fo = rsp_found;
        io = rsp_idx;
        eo = rsp_err;
        if (auto_ack) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [3:0] key,
                       input int ef, input int ei, input int ee, input int el);
        issue(op, key);
        collect(f, i, e, lat);
        check({tag, ".found"}, f, ef);
        check({tag, ".idx"}, i, ei);
        check({tag, ".err"}, e, ee);
        check({tag, ".lat"}, lat, el);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.cmd_ready", cmd_ready, 0);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rsp_idx", rsp_idx, 7);
        check("rst.rsp_found", rsp_found, 0);
        check("rst.rsp_err", rsp_err, 0);
        check("rst.empty", buf_empty, 1);
        rst = 1'b1;
        @(negedge clk);
        check("idle.cmd_ready", cmd_ready, 1);

        run("ins5", INS, 4'd5, 0, 0, 0, 1);
        run("ins3", INS, 4'd3, 0, 1, 0, 3);
        run("ins8", INS, 4'd8, 0, 2, 0, 3);
        check("cnt3", tree_counter, 3);
        check("left0", u_dut.u_mem.left_mem[0], 1);
        check("right0", u_dut.u_mem.right_mem[0], 2);
        run("find3", FIND, 4'd3, 1, 1, 0, 3);
        run("find4", FIND, 4'd4, 0, 7, 0, 3);
        run("dup3", INS, 4'd3, 1, 1, 0, 3);
        check("dup.cnt", tree_counter, 3);
        check("dup.left1", u_dut.u_mem.left_mem[1], 7);
        check("dup.right1", u_dut.u_mem.right_mem[1], 7);
        run("find8", FIND, 4'd8, 1, 2, 0, 3);

        run("clr1", CLR, 4'd0, 0, 7, 0, 1);
        check("clr1.empty", buf_empty, 1);
        for (int k = 1; k <= 7; k++)
            run($sformatf("chain%0d", k), INS, 4'(k), 0, k - 1, 0, k == 1 ? 1 : k + 1);
        check("chain.cnt", tree_counter, 7);
        check("chain.full", buf_full, 1);
        run("find7", FIND, 4'd7, 1, 6, 0, 8);
        run("insfull", INS, 4'd9, 0, 7, 1, 1);
        check("full.cnt", tree_counter, 7);

        auto_ack = 1'b0;
        run("hold", FIND, 4'd3, 1, 2, 0, 4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold.valid", rsp_valid, 1);
            check("hold.idx", rsp_idx, 2);
            check("hold.found", rsp_found, 1);
            check("hold.ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        auto_ack = 1'b1;
        @(negedge clk);
        check("hold.release", cmd_ready, 1);
        run("clr2", CLR, 4'd0, 0, 7, 0, 1);
        check("clr2.cnt", tree_counter, 0);
        check("clr2.empty", buf_empty, 1);
        run("find5e", FIND, 4'd5, 0, 7, 0, 1);

        run("root5", INS, 4'd5, 0, 0, 0, 1);
        issue(INS, 4'd3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("wrst.ready", cmd_ready, 0);
        check("wrst.valid", rsp_valid, 0);
        check("wrst.cnt", tree_counter, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("wrst.left0", u_dut.u_mem.left_mem[0], 7);
        check("wrst.idle", cmd_ready, 1);

        run("root5b", INS, 4'd5, 0, 0, 0, 1);
        issue(INS, 4'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("lrst.left0", u_dut.u_mem.left_mem[0], 7);
        check("lrst.cnt", tree_counter, 0);
        check("lrst.valid", rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
